axi_multiport_bridge: RTL and testbench
=======================================

Name: axi_multiport_bridge

Overview:
Parametrised successor to the fixed two-port sram-like-to-AXI bridge. Serves NUM_PORTS sram-like masters (port 0 = inst, port 1 = data, extra ports for future uncached/DMA masters) through one AXI3 master interface. Arbitration is round-robin. Multiple reads may be outstanding per port, routed back by ID. One write is in flight at a time, with a read-after-write hazard check. Sits between the pipeline stages and the AXI ports of cpu_core.

Parameters:
NUM_PORTS, 2, number of sram-like masters (1..8); the port index is used as the AXI ID.
MAX_RD, 4, maximum outstanding reads per port (1..15).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req  in  NUM_PORTS  per-port request
wr  in  NUM_PORTS  per-port write flag
size  in  2*NUM_PORTS  per-port size (0=byte, 1=half, 2=word)
wstrb  in  4*NUM_PORTS  per-port byte strobes
addr  in  32*NUM_PORTS  per-port address (virt_t slices)
wdata  in  32*NUM_PORTS  per-port write data
addr_ok  out  NUM_PORTS  request accepted this cycle
data_ok  out  NUM_PORTS  read data / write response returned
rdata  out  32*NUM_PORTS  per-port read data, valid with data_ok
ar*/r*/aw*/w*/b*  AXI3 master channels, same names/widths as cpu_core top (arid..bready)

Behaviour:
- Reset (resetn=0, asynchronous): arvalid, awvalid, wvalid, bready = 0; addr_ok, data_ok = 0; all read counters = 0; rr_ptr = 0; write FSM = W_IDLE.
- Handshake: request from port p accepted iff req[p] & addr_ok[p]. addr_ok is combinational. At most one addr_ok bit high per cycle.
- Arbitration: grant the first requesting, eligible port at or after rr_ptr (wrapping). After a handshake, rr_ptr = grant+1 mod NUM_PORTS; otherwise unchanged.
- Read eligibility for p: all of the following hold:
  - the AR slot is empty;
  - rd_cnt[p] < MAX_RD;
  - no RAW hazard: the write FSM is not idle and addr[31:2] equals the pending write address[31:2].
- Read accept: load the AR slot and assert arvalid next cycle.
  - araddr = addr, arid = p, arsize = {0,size}, arlen = 0, arburst = 2'b01, arlock/arcache/arprot = 0.
  - arvalid holds with stable fields until arready.
  - rd_cnt[p]++.
- Read return: rready = 1 always. On rvalid: data_ok[rid] = 1 and rdata[rid] = rdata in the same cycle (combinational route); rd_cnt[rid]-- on rlast.
  - Increment and decrement of the same counter in one cycle leave it unchanged.
  - rresp is ignored.
- Write eligibility for p: write FSM in W_IDLE and rd_cnt[p] == 0. This gives same-port ordering; cross-port WAR ordering is not guaranteed.
- Write FSM:
  - W_IDLE --accept--> W_REQ: latch addr/size/wstrb/wdata/owner. awvalid = wvalid = 1 next cycle; awid = wid = owner; awlen = 0; wlast = 1.
  - W_REQ: awvalid drops on awready and wvalid drops on wready, independently and in either order. When both are done, go to W_RESP.
  - W_RESP: bready = 1, except it is 0 in any cycle where rvalid & rid == owner (read return has priority on the shared data_ok). On bvalid & bready: data_ok[owner] = 1, go to W_IDLE. bresp is ignored.
  - A new write is accepted at the earliest the cycle after the return to W_IDLE.
- Boundaries:
  - rd_cnt at MAX_RD blocks that port only.
  - rid >= NUM_PORTS is dropped (no data_ok, no counter change).
  - Reset mid-transaction aborts all state; no response is produced after reset.

Decomposition:
- Shared package cpu_defs.svh gains: typedef axi_wr_state_t (W_IDLE, W_REQ, W_RESP); constants AXI_BURST_INCR = 2'b01 and AXI_LEN_SINGLE = 8'd0; typedef axi_id_t (4 bits).
- One sub-module: rr_arbiter. Parameter N; inputs req and eligible vectors plus an advance strobe; outputs a one-hot grant; holds its own pointer.

Test Plan:
- Single read: port 0 reads 0xBFC00000, arready after 2 cycles, rvalid with 0x3C1D0000 -> arid=0, data_ok[0] pulse with rdata[0]=0x3C1D0000, rd_cnt[0] back to 0.
- Contention: ports 0 and 1 both request reads every cycle -> grants alternate 0,1,0,1; after 4 reads with no rvalid (MAX_RD=4), port 0 gets no further addr_ok while port 1 continues up to its own limit.
- Out-of-order IDs: reads issued from port 0 then port 1; rvalid rid=1 before rid=0 -> data_ok[1] first, then data_ok[0], each with correct data.
- Write: port 1 writes 0x800000F0 with wstrb=4'b0011, wdata=0x1234ABCD; wready 3 cycles before awready -> one W beat and one AW, data_ok[1] only after bvalid.
- RAW hazard: during that write, port 0 reads 0x800000F2 -> addr_ok[0]=0 until the bresp cycle; it is accepted afterwards. A read of 0x800000F4 is accepted immediately.
- Collision and reset: bvalid and rvalid rid=owner in the same cycle -> bready=0, read data_ok that cycle, write data_ok next. Assert resetn=0 with arvalid high -> arvalid=0 immediately and counters cleared.

Source files
------------

// File: rtl/axi_multiport_bridge_pkg.sv
// axi_multiport_bridge_pkg: shared types and AXI constants for the multiport bridge
package axi_multiport_bridge_pkg;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} axi_wr_state_t;
  typedef logic [3:0] axi_id_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
endpackage

// File: rtl/axi_multiport_bridge_rr_arbiter.sv
// axi_multiport_bridge_rr_arbiter: round-robin grant among requesting, eligible ports
// Ports: clk/resetn (async active-low); req, eligible: per-port vectors;
//        advance: handshake happened, move pointer past the winner; grant: one-hot winner.
module axi_multiport_bridge_rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] req,
  input  logic [N-1:0] eligible,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr, idx, k;
  // Scan offsets from highest to lowest so the candidate nearest ptr wins.
  always_comb begin
    grant = '0;
    idx = ptr;
    k = ptr;
    for (int i = N - 1; i >= 0; i--) begin
      k = PW'((int'(ptr) + i) % N);
      if (req[k] && eligible[k]) idx = k;
    end
    grant[idx] = |(req & eligible);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) ptr <= '0;
    else if (advance) ptr <= (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
endmodule

// File: rtl/axi_multiport_bridge.sv
// axi_multiport_bridge: NUM_PORTS sram-like masters onto one AXI3 master, round-robin
// Ports: clk, resetn (async active-low);
//        per-port sram side: req, wr, size, wstrb, addr, wdata -> addr_ok, data_ok, rdata;
//        AXI3 master: ar*, r*, aw*, w*, b*; the AXI read/write data and strobes are
//        named axi_rdata/axi_wdata/axi_wstrb so they do not collide with the sram side.
module axi_multiport_bridge
  import axi_multiport_bridge_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int MAX_RD    = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_PORTS-1:0]   req,
  input  logic [NUM_PORTS-1:0]   wr,
  input  logic [2*NUM_PORTS-1:0] size,
  input  logic [4*NUM_PORTS-1:0] wstrb,
  input  logic [32*NUM_PORTS-1:0] addr,
  input  logic [32*NUM_PORTS-1:0] wdata,
  output logic [NUM_PORTS-1:0]   addr_ok,
  output logic [NUM_PORTS-1:0]   data_ok,
  output logic [32*NUM_PORTS-1:0] rdata,
  output axi_id_t                arid,
  output logic [31:0]            araddr,
  output logic [7:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  output logic [1:0]             arlock,
  output logic [3:0]             arcache,
  output logic [2:0]             arprot,
  output logic                   arvalid,
  input  logic                   arready,
  input  axi_id_t                rid,
  input  logic [31:0]            axi_rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready,
  output axi_id_t                awid,
  output logic [31:0]            awaddr,
  output logic [7:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic [1:0]             awlock,
  output logic [3:0]             awcache,
  output logic [2:0]             awprot,
  output logic                   awvalid,
  input  logic                   awready,
  output axi_id_t                wid,
  output logic [31:0]            axi_wdata,
  output logic [3:0]             axi_wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,
  input  axi_id_t                bid,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready
);
  axi_wr_state_t state, state_n;
  logic [3:0] rd_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] elig, grant;
  axi_id_t g_id, w_owner;
  logic g_wr, rd_acc, wr_acc;
  logic [31:0] g_addr, g_data;
  logic [1:0] g_size, w_size;
  logic [3:0] g_strb;
  logic unused;
  assign unused = ^{rresp, bresp, bid};
  // Writes wait for the port's reads to drain; reads stall on a word-address match with the pending write.
  always_comb
    for (int i = 0; i < NUM_PORTS; i++)
      elig[i] = wr[i] ? (state == W_IDLE && rd_cnt[i] == 4'd0)
                      : (!arvalid && rd_cnt[i] < 4'(MAX_RD) &&
                         !(state != W_IDLE && addr[32*i+2 +: 30] == awaddr[31:2]));
  axi_multiport_bridge_rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk(clk),
    .resetn(resetn),
    .req(req & {NUM_PORTS{resetn}}),
    .eligible(elig),
    .advance(|grant),
    .grant(grant)
  );
  assign addr_ok = grant;
  always_comb begin
    g_id = '0;
    g_wr = 1'b0;
    g_addr = '0;
    g_size = '0;
    g_strb = '0;
    g_data = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (grant[i]) begin
        g_id = axi_id_t'(i);
        g_wr = wr[i];
        g_addr = addr[32*i +: 32];
        g_size = size[2*i +: 2];
        g_strb = wstrb[4*i +: 4];
        g_data = wdata[32*i +: 32];
      end
  end
  assign rd_acc = |grant && !g_wr;
  assign wr_acc = |grant && g_wr;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      arvalid <= 1'b0;
      arid <= '0;
      araddr <= '0;
      arsize <= '0;
    end else if (rd_acc) begin
      arvalid <= 1'b1;
      arid <= g_id;
      araddr <= g_addr;
      arsize <= {1'b0, g_size};
    end else if (arready) arvalid <= 1'b0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) for (int i = 0; i < NUM_PORTS; i++) rd_cnt[i] <= '0;
    else
      for (int i = 0; i < NUM_PORTS; i++)
        rd_cnt[i] <= rd_cnt[i] + 4'(rd_acc && g_id == axi_id_t'(i))
                               - 4'(rvalid && rlast && rid == axi_id_t'(i));
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= W_IDLE;
    else state <= state_n;
  always_comb
    state_n = (state == W_IDLE && wr_acc) ? W_REQ
            : (state == W_REQ && (!awvalid || awready) && (!wvalid || wready)) ? W_RESP
            : (state == W_RESP && bvalid && bready) ? W_IDLE : state;
  // A read return to the write owner takes the shared data_ok, so the B handshake waits a cycle.
  always_comb begin
    bready = state == W_RESP && !(rvalid && rid == w_owner);
    for (int i = 0; i < NUM_PORTS; i++)
      data_ok[i] = resetn && ((rvalid && rid == axi_id_t'(i)) ||
                              (bvalid && bready && w_owner == axi_id_t'(i)));
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      awvalid <= 1'b0;
      wvalid <= 1'b0;
      awaddr <= '0;
      w_size <= '0;
      axi_wstrb <= '0;
      axi_wdata <= '0;
      w_owner <= '0;
    end else if (wr_acc) begin
      awvalid <= 1'b1;
      wvalid <= 1'b1;
      awaddr <= g_addr;
      w_size <= g_size;
      axi_wstrb <= g_strb;
      axi_wdata <= g_data;
      w_owner <= g_id;
    end else begin
      if (awready) awvalid <= 1'b0;
      if (wready) wvalid <= 1'b0;
    end
  assign rdata = {NUM_PORTS{axi_rdata}};
  assign rready = 1'b1;
  assign arlen = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock = '0;
  assign arcache = '0;
  assign arprot = '0;
  assign awid = w_owner;
  assign awlen = AXI_LEN_SINGLE;
  assign awsize = {1'b0, w_size};
  assign awburst = AXI_BURST_INCR;
  assign awlock = '0;
  assign awcache = '0;
  assign awprot = '0;
  assign wid = w_owner;
  assign wlast = 1'b1;
endmodule

// File: tb/tb_axi_multiport_bridge.sv
// tb_axi_multiport_bridge: directed self-checking bench for axi_multiport_bridge
module tb_axi_multiport_bridge;
  logic clk = 1'b0, resetn = 1'b0;
  logic [1:0] req = '0, wr = '0, addr_ok, data_ok;
  logic [3:0] size = '0;
  logic [7:0] wstrb = '0;
  logic [63:0] addr = '0, wdata = '0, rdata;
  logic [3:0] arid, awid, wid, rid = '0, bid = '0, arcache, awcache, axi_wstrb;
  logic [31:0] araddr, awaddr, axi_rdata = '0, axi_wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst, arlock, awlock, rresp = '0, bresp = '0;
  logic arvalid, arready = 1'b0, rlast = 1'b1, rvalid = 1'b0, rready;
  logic awvalid, awready = 1'b0, wlast, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
  int total = 0, passed = 0, failed = 0;
  logic [1:0] exp_ok [18];
  axi_multiport_bridge #(.NUM_PORTS(2), .MAX_RD(4)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .axi_rdata(axi_rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    exp_ok = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2,
               2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
    tick;
    tick;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_addr_ok", addr_ok, 0);
    chk("rst_data_ok", data_ok, 0);
    chk("rst_rready", rready, 1);
    resetn = 1'b1;
    tick;
    // single read from port 0
    req = 2'b01; addr[31:0] = 32'hBFC00000; size = 4'b1010;
    #1 chk("rd1_addr_ok", addr_ok, 2'b01);
    tick;
    req = 2'b00;
    #1 chk("rd1_arvalid", arvalid, 1);
    chk("rd1_araddr", araddr, 32'hBFC00000);
    chk("rd1_arid", arid, 0);
    chk("rd1_arsize", arsize, 3'd2);
    chk("rd1_arlen", arlen, 0);
    chk("rd1_arburst", arburst, 2'b01);
    tick;
    #1 chk("rd1_hold", arvalid, 1);
    tick;
    arready = 1'b1;
    #1 chk("rd1_hold2", arvalid, 1);
    tick;
    #1 chk("rd1_ar_done", arvalid, 0);
    rvalid = 1'b1; rid = 4'd0; axi_rdata = 32'h3C1D0000;
    #1 chk("rd1_data_ok", data_ok, 2'b01);
    chk("rd1_rdata", rdata[31:0], 32'h3C1D0000);
    tick;
    rvalid = 1'b0;
    #1 chk("rd1_data_ok_off", data_ok, 0);
    chk("rd1_cnt", dut.rd_cnt[0], 0);
    // contention: rr pointer is 1 after port 0's grant, so port 1 goes first
    req = 2'b11; wr = 2'b00; addr = {32'h00002000, 32'h00001000};
    for (int k = 0; k < 18; k++) begin
      #1 chk($sformatf("cont_ok_%0d", k), addr_ok, exp_ok[k]);
      if (k % 2 == 1 && k < 16) chk($sformatf("cont_arid_%0d", k), arid, exp_ok[k-1] == 2'd2 ? 1 : 0);
      tick;
    end
    req = 2'b00;
    chk("cont_cnt0", dut.rd_cnt[0], 4);
    chk("cont_cnt1", dut.rd_cnt[1], 4);
    rvalid = 1'b1; rid = 4'd5; axi_rdata = 32'hDEADBEEF;
    #1 chk("bad_rid_data_ok", data_ok, 0);
    tick;
    rvalid = 1'b0;
    #1 chk("bad_rid_cnt0", dut.rd_cnt[0], 4);
    chk("bad_rid_cnt1", dut.rd_cnt[1], 4);
    rvalid = 1'b1; rid = 4'd1; axi_rdata = 32'hAAAA0001;
    #1 chk("free1_data_ok", data_ok, 2'b10);
    chk("free1_rdata", rdata[63:32], 32'hAAAA0001);
    tick;
    rvalid = 1'b0; req = 2'b11;
    #1 chk("free1_port1_only", addr_ok, 2'b10);
    tick;
    req = 2'b00;
    for (int i = 0; i < 8; i++) begin
      rvalid = 1'b1; rid = 4'(i % 2); axi_rdata = 32'h5000 + i;
      #1 chk($sformatf("drain_%0d", i), data_ok, (i % 2) ? 2'b10 : 2'b01);
      tick;
    end
    rvalid = 1'b0;
    #1 chk("drain_cnt0", dut.rd_cnt[0], 0);
    chk("drain_cnt1", dut.rd_cnt[1], 0);
    // out-of-order returns
    req = 2'b01; addr[31:0] = 32'h100;
    #1 chk("ooo_ok0", addr_ok, 2'b01);
    tick;
    req = 2'b10; addr[63:32] = 32'h200;
    #1 chk("ooo_slot_busy", addr_ok, 0);
    tick;
    #1 chk("ooo_ok1", addr_ok, 2'b10);
    tick;
    req = 2'b00;
    tick;
    rvalid = 1'b1; rid = 4'd1; axi_rdata = 32'h11111111;
    #1 chk("ooo_first", data_ok, 2'b10);
    chk("ooo_first_data", rdata[63:32], 32'h11111111);
    tick;
    rid = 4'd0; axi_rdata = 32'h22222222;
    #1 chk("ooo_second", data_ok, 2'b01);
    chk("ooo_second_data", rdata[31:0], 32'h22222222);
    tick;
    rvalid = 1'b0;
    // write from port 1, W accepted three cycles before AW
    req = 2'b10; wr = 2'b10; addr[63:32] = 32'h800000F0; size = 4'b0110;
    wstrb = 8'h30; wdata[63:32] = 32'h1234ABCD;
    #1 chk("wr_addr_ok", addr_ok, 2'b10);
    tick;
    req = 2'b00; wr = 2'b00; wready = 1'b1;
    #1 chk("wr_awvalid", awvalid, 1);
    chk("wr_wvalid", wvalid, 1);
    chk("wr_awaddr", awaddr, 32'h800000F0);
    chk("wr_awid", awid, 1);
    chk("wr_wid", wid, 1);
    chk("wr_wstrb", axi_wstrb, 4'b0011);
    chk("wr_wdata", axi_wdata, 32'h1234ABCD);
    chk("wr_wlast", wlast, 1);
    chk("wr_awsize", awsize, 3'd1);
    chk("wr_awlen", awlen, 0);
    tick;
    wready = 1'b0; req = 2'b01; addr[31:0] = 32'h800000F2;
    #1 chk("wr_w_done", wvalid, 0);
    chk("wr_aw_hold", awvalid, 1);
    chk("raw_block", addr_ok, 0);
    tick;
    addr[31:0] = 32'h800000F4;
    #1 chk("raw_other_word", addr_ok, 2'b01);
    tick;
    req = 2'b00; awready = 1'b1;
    #1 chk("wr_aw_late", awvalid, 1);
    chk("wr_no_early_ok", data_ok, 0);
    tick;
    awready = 1'b0; req = 2'b01; addr[31:0] = 32'h800000F2;
    #1 chk("wr_aw_done", awvalid, 0);
    chk("wr_bready", bready, 1);
    chk("raw_block_resp", addr_ok, 0);
    chk("wr_wait_b", data_ok, 0);
    tick;
    bvalid = 1'b1; bid = 4'd1;
    #1 chk("wr_data_ok", data_ok, 2'b10);
    chk("raw_block_bcycle", addr_ok, 0);
    tick;
    bvalid = 1'b0;
    #1 chk("raw_release", addr_ok, 2'b01);
    tick;
    req = 2'b00;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rid = 4'd0;
      #1 chk($sformatf("raw_ret_%0d", i), data_ok, 2'b01);
      tick;
    end
    rvalid = 1'b0;
    #1 chk("raw_cnt0", dut.rd_cnt[0], 0);
    // B and R to the write owner in the same cycle
    req = 2'b10; wr = 2'b10; addr[63:32] = 32'h900; wstrb = 8'hF0; wdata[63:32] = 32'h55;
    #1 chk("col_wr_ok", addr_ok, 2'b10);
    tick;
    wr = 2'b00; addr[63:32] = 32'hA00; awready = 1'b1; wready = 1'b1;
    #1 chk("col_rd_ok", addr_ok, 2'b10);
    tick;
    req = 2'b00; awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bid = 4'd1; rvalid = 1'b1; rid = 4'd1; axi_rdata = 32'hCAFEF00D;
    #1 chk("col_bready", bready, 0);
    chk("col_rd_ok_out", data_ok, 2'b10);
    chk("col_rdata", rdata[63:32], 32'hCAFEF00D);
    tick;
    rvalid = 1'b0;
    #1 chk("col_bready2", bready, 1);
    chk("col_wr_ok_out", data_ok, 2'b10);
    tick;
    bvalid = 1'b0;
    #1 chk("col_idle", data_ok, 0);
    chk("col_cnt1", dut.rd_cnt[1], 0);
    // asynchronous reset while a read address is pending
    arready = 1'b0; req = 2'b01; addr[31:0] = 32'hB00;
    #1 chk("rst_mid_ok", addr_ok, 2'b01);
    tick;
    req = 2'b00;
    #1 chk("rst_mid_arvalid", arvalid, 1);
    #2 resetn = 1'b0; rvalid = 1'b1; rid = 4'd0;
    #1 chk("rst_async_arvalid", arvalid, 0);
    chk("rst_async_cnt0", dut.rd_cnt[0], 0);
    chk("rst_async_data_ok", data_ok, 0);
    rvalid = 1'b0;
    tick;
    resetn = 1'b1;
    tick;
    #1 chk("rst_after_arvalid", arvalid, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
